// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle processor: opcodes, branch conditions, steps, bus selects.
// Pure definitions; no timing or flow control.
package proc_pkg;

    localparam logic [2:0] OP_MV    = 3'b000;
    localparam logic [2:0] OP_MVT_B = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_CS = 3'b100;
    localparam logic [2:0] COND_PL = 3'b101;
    localparam logic [2:0] COND_MI = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_t;

    typedef enum logic [3:0] {
        SEL_R0, SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5, SEL_R6, SEL_R7,
        SEL_G, SEL_IMM_SEXT, SEL_IMM_HI, SEL_DIN
    } bus_sel_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;

    function automatic logic cond_true(input logic [2:0] cond, input logic z, input logic n,
                                       input logic c);
        logic ok;
        case (cond)
            COND_AL: ok = 1'b1;
            COND_EQ: ok = z;
            COND_NE: ok = !z;
            COND_CC: ok = !c;
            COND_CS: ok = c;
            COND_PL: ok = !n;
            COND_MI: ok = n;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/proc_if.sv
// Processor-to-memory/IO bus: fetch enable, read data, registered address/data/write strobe, Done.
// No handshake: memory is assumed to answer with a fixed one-cycle read latency.
interface proc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DOUT;
    logic              W;
    logic              Done;

    modport master (input Run, DIN, output ADDR, DOUT, W, Done);
    modport slave  (output Run, DIN, input ADDR, DOUT, W, Done);
endinterface

// File: rtl/proc_alu.sv
// Combinational add/sub/and with zero, negative and carry outputs.
// Zero latency; no flow control.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] g,
    output logic              z,
    output logic              n,
    output logic              c
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum = '0;
        case (op)
            ALU_ADD: sum = {1'b0, a} + {1'b0, b};
            // Subtract as a + ~b + 1 so carry out means "no borrow".
            ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
            default: sum = {1'b0, a & b};
        endcase
    end

    assign g = sum[DATA_W-1:0];
    assign c = sum[DATA_W];
    assign z = (g == '0);
    assign n = g[DATA_W-1];

endmodule

// File: rtl/proc_core.sv
// Multicycle processor fetching 16-bit instructions via r7; mv/mvt/alu/branch/ld/st.
// 4 cycles for mv/mvt/no-op/untaken branch, 6 otherwise; stalls in T0 while Run is low.
module proc_core
    import proc_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic   Clock,
    input  logic   Resetn,
    proc_if.master bus
);

    logic [DATA_W-1:0] rf [8];
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;
    logic              z_flag, n_flag, c_flag;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              w_reg;
    step_t             state, state_nxt;

    logic [2:0]        opc, rx, ry;
    logic              imm_bit;
    logic [DATA_W-1:0] imm_sext, imm_hi;
    logic              cond_ok;

    assign opc      = ir[15:13];
    assign imm_bit  = ir[12];
    assign rx       = ir[11:9];
    assign ry       = ir[2:0];
    assign imm_sext = {{(DATA_W-9){ir[8]}}, ir[8:0]};
    assign imm_hi   = {ir[7:0], {(DATA_W-8){1'b0}}};
    assign cond_ok  = cond_true(rx, z_flag, n_flag, c_flag);

    bus_sel_t          bus_sel;
    logic [DATA_W-1:0] bus_val;
    logic [2:0]        rf_waddr;
    logic              ir_we, pc_inc, addr_we, rf_we, a_we, g_we, flags_we;
    logic              dout_we, w_set, w_clr, done;

    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b, alu_g;
    logic              alu_z, alu_n, alu_c;

    always_comb begin
        case (opc)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // Branches always add the immediate; the ALU ops choose by the I bit.
    assign alu_b = (opc == OP_MVT_B || imm_bit) ? imm_sext : rf[ry];

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op),
        .a  (a_reg),
        .b  (alu_b),
        .g  (alu_g),
        .z  (alu_z),
        .n  (alu_n),
        .c  (alu_c)
    );

    always_comb begin
        case (bus_sel)
            SEL_G:        bus_val = g_reg;
            SEL_IMM_SEXT: bus_val = imm_sext;
            SEL_IMM_HI:   bus_val = imm_hi;
            SEL_DIN:      bus_val = bus.DIN;
            default:      bus_val = rf[bus_sel[2:0]];
        endcase
    end

    always_comb begin
        state_nxt = state;
        bus_sel   = SEL_R7;
        rf_waddr  = rx;
        ir_we     = 1'b0;
        pc_inc    = 1'b0;
        addr_we   = 1'b0;
        rf_we     = 1'b0;
        a_we      = 1'b0;
        g_we      = 1'b0;
        flags_we  = 1'b0;
        dout_we   = 1'b0;
        w_set     = 1'b0;
        w_clr     = 1'b0;
        done      = 1'b0;
        case (state)
            T0: begin
                if (bus.Run) begin
                    addr_we   = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: state_nxt = T2;
            T2: begin
                ir_we     = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                state_nxt = T4;
                case (opc)
                    OP_MV: begin
                        bus_sel   = imm_bit ? SEL_IMM_SEXT : bus_sel_t'({1'b0, ry});
                        rf_we     = 1'b1;
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_MVT_B: begin
                        if (imm_bit) begin
                            bus_sel   = SEL_IMM_HI;
                            rf_we     = 1'b1;
                            done      = 1'b1;
                            state_nxt = T0;
                        end else begin
                            bus_sel = SEL_R7;
                            a_we    = 1'b1;
                            if (!cond_ok) begin
                                done      = 1'b1;
                                state_nxt = T0;
                            end
                        end
                    end
                    OP_LD, OP_ST: begin
                        bus_sel = bus_sel_t'({1'b0, ry});
                        addr_we = 1'b1;
                    end
                    OP_NOP: begin
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                    default: begin
                        bus_sel = bus_sel_t'({1'b0, rx});
                        a_we    = 1'b1;
                    end
                endcase
            end
            T4: begin
                state_nxt = T5;
                case (opc)
                    OP_ADD, OP_SUB, OP_AND: begin
                        g_we     = 1'b1;
                        flags_we = 1'b1;
                    end
                    OP_MVT_B: g_we = 1'b1;
                    OP_ST: begin
                        bus_sel = bus_sel_t'({1'b0, rx});
                        dout_we = 1'b1;
                        w_set   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                done      = 1'b1;
                w_clr     = 1'b1;
                state_nxt = T0;
                case (opc)
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_sel = SEL_G;
                        rf_we   = 1'b1;
                    end
                    OP_MVT_B: begin
                        bus_sel  = SEL_G;
                        rf_waddr = 3'd7;
                        rf_we    = 1'b1;
                    end
                    OP_LD: begin
                        bus_sel = SEL_DIN;
                        rf_we   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_nxt = T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= T0;
            for (int i = 0; i < 7; i++) rf[i] <= '0;
            rf[7]    <= RESET_PC;
            ir       <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            z_flag   <= 1'b0;
            n_flag   <= 1'b0;
            c_flag   <= 1'b0;
            addr_reg <= '0;
            dout_reg <= '0;
            w_reg    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pc_inc)  rf[7] <= rf[7] + DATA_W'(1);
            // A register write to r7 is a jump and overrides the increment.
            if (rf_we)   rf[rf_waddr] <= bus_val;
            if (ir_we)   ir <= bus.DIN[15:0];
            if (a_we)    a_reg <= bus_val;
            if (g_we)    g_reg <= alu_g;
            if (flags_we) begin
                z_flag <= alu_z;
                n_flag <= alu_n;
                c_flag <= alu_c;
            end
            if (addr_we) addr_reg <= bus_val[ADDR_W-1:0];
            if (dout_we) dout_reg <= bus_val;
            if (w_set)      w_reg <= 1'b1;
            else if (w_clr) w_reg <= 1'b0;
        end
    end

    assign bus.ADDR = addr_reg;
    assign bus.DOUT = dout_reg;
    assign bus.W    = w_reg;
    assign bus.Done = done;

endmodule

// File: tb/tb_proc_core.sv
// Directed programs run on a small synchronous memory model; expectations hand-computed.
module tb_proc_core;
    import proc_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;

    logic Clock = 1'b0;
    logic Resetn;

    proc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    proc_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(16'h0000)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr;
    logic [15:0] ld_dat;

    always @(posedge Clock) begin
        if (ld_en) mem[ld_addr] <= ld_dat;
        else if (bus.W) mem[bus.ADDR[7:0]] <= bus.DOUT;
        bus.DIN <= mem[bus.ADDR[7:0]];
    end

    int errors = 0;
    int checks = 0;

    task automatic do_reset();
        bus.Run = 1'b0;
        Resetn  = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        @(posedge Clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) load(8'(i), 16'h0000);
    endtask

    task automatic start();
        Resetn  = 1'b1;
        bus.Run = 1'b1;
    endtask

    // Runs one instruction from its T0 cycle up to the following T0; counts cycles and W pulses.
    task automatic step(output int cyc, output int wcnt, output logic [15:0] waddr,
                        output logic [15:0] wdat);
        cyc = 1; wcnt = 0; waddr = '0; wdat = '0;
        while (bus.Done !== 1'b1 && cyc < 12) begin
            @(posedge Clock); #1;
            cyc++;
            if (bus.W === 1'b1) begin wcnt++; waddr = bus.ADDR; wdat = bus.DOUT; end
        end
        checks++;
        if (bus.Done !== 1'b1) begin errors++; $display("FAIL step_timeout: Done=%b after %0d cycles, want 1", bus.Done, cyc); end
        @(posedge Clock); #1;
        if (bus.W === 1'b1) wcnt++;
    endtask

    int cyc, wcnt;
    logic [15:0] waddr, wdat;

    task automatic test_reset();
        do_reset();
        checks++; if (dut.rf[7] !== 16'h0000) begin errors++; $display("FAIL reset_r7: got %h want 0000", dut.rf[7]); end
        checks++; if (bus.ADDR !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.ADDR); end
        checks++; if (bus.W !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL reset_w_done: got W=%b Done=%b want 0 0", bus.W, bus.Done); end
        checks++; if (bus.DOUT !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", bus.DOUT); end
        Resetn = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
        checks++; if (dut.rf[7] !== 16'h0000 || bus.Done !== 1'b0) begin errors++; $display("FAIL run_low_idle: got r7=%h Done=%b want 0000 0", dut.rf[7], bus.Done); end
    endtask

    task automatic test_mv();
        do_reset(); clear_mem();
        load(8'h00, 16'h1205);
        start();
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL mv_latency: got %0d want 4", cyc); end
        checks++; if (dut.rf[1] !== 16'h0005) begin errors++; $display("FAIL mv_r1: got %h want 0005", dut.rf[1]); end
        checks++; if (dut.rf[7] !== 16'h0001) begin errors++; $display("FAIL mv_r7: got %h want 0001", dut.rf[7]); end
    endtask

    task automatic test_mvt();
        do_reset(); clear_mem();
        load(8'h00, 16'h15FF);
        load(8'h01, 16'h36AB);
        start();
        step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[2] !== 16'hFFFF) begin errors++; $display("FAIL mv_sext_r2: got %h want ffff", dut.rf[2]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL mvt_latency: got %0d want 4", cyc); end
        checks++; if (dut.rf[3] !== 16'hAB00) begin errors++; $display("FAIL mvt_r3: got %h want ab00", dut.rf[3]); end
    endtask

    task automatic test_sub_beq();
        do_reset(); clear_mem();
        load(8'h00, 16'h1205);
        load(8'h01, 16'h1405);
        load(8'h02, 16'h6202);
        load(8'h03, 16'h23FE);
        start();
        step(cyc, wcnt, waddr, wdat);
        step(cyc, wcnt, waddr, wdat);
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL sub_latency: got %0d want 6", cyc); end
        checks++; if (dut.rf[1] !== 16'h0000) begin errors++; $display("FAIL sub_r1: got %h want 0000", dut.rf[1]); end
        checks++; if ({dut.z_flag, dut.n_flag, dut.c_flag} !== 3'b101) begin errors++; $display("FAIL sub_flags: got znc=%b want 101", {dut.z_flag, dut.n_flag, dut.c_flag}); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL beq_taken_latency: got %0d want 6", cyc); end
        checks++; if (dut.rf[7] !== 16'h0002) begin errors++; $display("FAIL beq_target: got %h want 0002", dut.rf[7]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[1] !== 16'hFFFB) begin errors++; $display("FAIL sub_borrow_r1: got %h want fffb", dut.rf[1]); end
        checks++; if ({dut.z_flag, dut.n_flag, dut.c_flag} !== 3'b010) begin errors++; $display("FAIL sub_borrow_flags: got znc=%b want 010", {dut.z_flag, dut.n_flag, dut.c_flag}); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 4 || dut.rf[7] !== 16'h0004) begin errors++; $display("FAIL beq_untaken: got cyc=%0d r7=%h want 4 0004", cyc, dut.rf[7]); end
    endtask

    task automatic test_add_bcc();
        do_reset(); clear_mem();
        load(8'h00, 16'h19FF);
        load(8'h01, 16'h5801);
        load(8'h02, 16'h2605);
        load(8'h03, 16'h1AF3);
        load(8'h04, 16'hDA3C);
        start();
        step(cyc, wcnt, waddr, wdat);
        step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[4] !== 16'h0000) begin errors++; $display("FAIL add_wrap_r4: got %h want 0000", dut.rf[4]); end
        checks++; if ({dut.z_flag, dut.n_flag, dut.c_flag} !== 3'b101) begin errors++; $display("FAIL add_flags: got znc=%b want 101", {dut.z_flag, dut.n_flag, dut.c_flag}); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL bcc_untaken_latency: got %0d want 4", cyc); end
        checks++; if (dut.rf[7] !== 16'h0003) begin errors++; $display("FAIL bcc_untaken_pc: got %h want 0003", dut.rf[7]); end
        step(cyc, wcnt, waddr, wdat);
        step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[5] !== 16'h0030) begin errors++; $display("FAIL and_r5: got %h want 0030", dut.rf[5]); end
        checks++; if ({dut.z_flag, dut.n_flag, dut.c_flag} !== 3'b000) begin errors++; $display("FAIL and_flags: got znc=%b want 000", {dut.z_flag, dut.n_flag, dut.c_flag}); end
    endtask

    task automatic test_st_ld();
        do_reset(); clear_mem();
        load(8'h00, 16'h1C20);
        load(8'h01, 16'h3A12);
        load(8'h02, 16'h5A34);
        load(8'h03, 16'hAA06);
        load(8'h04, 16'h8006);
        start();
        repeat (3) step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[5] !== 16'h1234) begin errors++; $display("FAIL build_r5: got %h want 1234", dut.rf[5]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL st_latency: got %0d want 6", cyc); end
        checks++; if (wcnt !== 1) begin errors++; $display("FAIL st_w_pulse: got %0d cycles want 1", wcnt); end
        checks++; if (waddr !== 16'h0020 || wdat !== 16'h1234) begin errors++; $display("FAIL st_bus: got addr=%h dout=%h want 0020 1234", waddr, wdat); end
        checks++; if (mem[8'h20] !== 16'h1234) begin errors++; $display("FAIL st_mem: got %h want 1234", mem[8'h20]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 6 || dut.rf[0] !== 16'h1234) begin errors++; $display("FAIL ld_r0: got cyc=%0d r0=%h want 6 1234", cyc, dut.rf[0]); end
    endtask

    task automatic test_branch_jump();
        do_reset(); clear_mem();
        load(8'h00, 16'h2002);
        load(8'h03, 16'h1207);
        load(8'h04, 16'h2E02);
        load(8'h05, 16'h1E10);
        load(8'h10, 16'hE000);
        start();
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 6 || dut.rf[7] !== 16'h0003) begin errors++; $display("FAIL b_always: got cyc=%0d r7=%h want 6 0003", cyc, dut.rf[7]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[1] !== 16'h0007) begin errors++; $display("FAIL b_target_exec: got %h want 0007", dut.rf[1]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (cyc !== 4 || dut.rf[7] !== 16'h0005) begin errors++; $display("FAIL b_never: got cyc=%0d r7=%h want 4 0005", cyc, dut.rf[7]); end
        step(cyc, wcnt, waddr, wdat);
        checks++; if (dut.rf[7] !== 16'h0010) begin errors++; $display("FAIL mv_r7_jump: got %h want 0010", dut.rf[7]); end
        // No-op at 0x10 with Run dropped after T0: must still finish, then idle.
        @(posedge Clock); #1;
        bus.Run = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL nop_done_t3: got %b want 1", bus.Done); end
        repeat (4) @(posedge Clock);
        #1;
        checks++; if (dut.rf[7] !== 16'h0011 || bus.Done !== 1'b0) begin errors++; $display("FAIL run_low_halt: got r7=%h Done=%b want 0011 0", dut.rf[7], bus.Done); end
    endtask

    task automatic test_reset_mid_st();
        do_reset(); clear_mem();
        load(8'h00, 16'h1C20);
        load(8'h01, 16'h1A55);
        load(8'h02, 16'hAA06);
        load(8'h20, 16'h0BAD);
        start();
        step(cyc, wcnt, waddr, wdat);
        step(cyc, wcnt, waddr, wdat);
        repeat (4) @(posedge Clock);
        #1;
        checks++; if (bus.ADDR !== 16'h0020) begin errors++; $display("FAIL st_t4_addr: got %h want 0020", bus.ADDR); end
        Resetn = 1'b0;
        #1;
        checks++; if (bus.W !== 1'b0 || bus.ADDR !== 16'h0000) begin errors++; $display("FAIL async_reset_bus: got W=%b ADDR=%h want 0 0000", bus.W, bus.ADDR); end
        checks++; if (dut.rf[7] !== 16'h0000) begin errors++; $display("FAIL async_reset_pc: got %h want 0000", dut.rf[7]); end
        repeat (3) @(posedge Clock);
        #1;
        checks++; if (mem[8'h20] !== 16'h0BAD) begin errors++; $display("FAIL aborted_st_mem: got %h want 0bad", mem[8'h20]); end
    endtask

    initial begin
        test_reset();
        test_mv();
        test_mvt();
        test_sub_beq();
        test_add_bcc();
        test_st_ld();
        test_branch_jump();
        test_reset_mid_st();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
